axi_read_arbiter: RTL
=====================

Name: axi_read_arbiter

Overview:
- Shares one AXI4 read port (64-bit, INCR bursts) between NUM_REQ burst requesters, e.g. video graphic-line fetch, video text-line fetch and future DMA clients.
- Allows one outstanding burst at a time. Each grant is a complete AR + R transaction.
- Read beats are steered only to the requester that owns the current burst.
- Sits between the video/DMA clients and the system memory interconnect, on the system clock domain.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 has highest fixed priority.
- DATA_W, 64, AXI read data width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a burst pending
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- req_addr  in  NUM_REQ*32  byte address of requester i, in slice [32*i+:32]
- req_len  in  NUM_REQ*8  AXI len (beats-1) of requester i, in slice [8*i+:8]
- rsp_valid  out  NUM_REQ  beat valid for requester i
- rsp_data  out  DATA_W  beat data, shared by all requesters
- rsp_last  out  1  final beat of the burst
- busy  out  1  a burst is in flight (state != IDLE)
- len_err  out  1  sticky flag: beat count disagreed with r_last
- axi_ar_valid  out  1
- axi_ar_ready  in  1
- axi_ar_payload_addr  out  32
- axi_ar_payload_len  out  8
- axi_ar_payload_burst  out  2  constant 2'd1 (INCR)
- axi_r_valid  in  1
- axi_r_ready  out  1
- axi_r_payload_data  in  DATA_W
- axi_r_payload_last  in  1

Behaviour:
- Clocking: one clock (clk); reset is synchronous, active-high.
- Reset values: state=IDLE; axi_ar_valid=0; req_ready=0; rsp_valid=0; rsp_last=0; len_err=0; busy=0; owner=0; beat_cnt=0; RR pointer=0.
- axi_r_ready: equals 1 in DATA and 0 otherwise. This is the combinational decode of the state register.
- IDLE:
  - If any req_valid is set, the picker selects winner w.
  - Latch addr/len from slice w and set owner=w. Pulse req_ready[w] in this same cycle. Go to ADDR.
  - If no req_valid is set, stay in IDLE.
- ADDR:
  - axi_ar_valid=1, with addr/len held stable.
  - On ar_valid & ar_ready: drop ar_valid, clear beat_cnt, go to DATA.
  - Any axi_r_valid seen in ADDR is ignored; r_ready=0.
- DATA:
  - On each axi_r_valid, the next cycle shows rsp_valid[owner]=1, rsp_data=r data and rsp_last=r last. Response latency is 1 registered cycle. All other rsp_valid bits stay 0.
  - beat_cnt increments on each beat.
  - On a beat with r_last: go to IDLE.
  - If beat_cnt != latched len on that beat, set len_err=1. len_err clears only on reset.
  - If beat_cnt reaches len+1 without r_last, set len_err=1 and stay in DATA until r_last arrives.
- Requester contract:
  - Requesters hold req_valid/addr/len stable until req_ready.
  - After req_ready the requester may change addr/len immediately.
  - Requesters must keep bursts within a 4 KB boundary. The arbiter does not split bursts.
- Back-to-back grants:
  - The earliest re-grant is the IDLE cycle after the last beat, giving a minimum 1-cycle gap between r_last and the next ar_valid assertion.
  - Between bursts, a requester whose req_valid drops before grant loses its slot, with no memory of the request.
- Fixed priority (default): the lowest asserted index wins.
- Reset mid-burst:
  - Return to IDLE and drop ar_valid/rsp_valid immediately.
  - Reset is system-wide, so the interconnect is reset together with this block. No drain is performed.
- Widths:
  - beat_cnt is 9 bits, so len=255 produces no wrap.
  - owner is $clog2(NUM_REQ) bits, minimum 1.

Optional Feature:
- Macro: AXI_READ_ARBITER_ROUND_ROBIN_EN.
- When defined:
  - Round-robin arbitration. The search starts at index (last_owner+1) mod NUM_REQ and wraps.
  - The pointer updates on each grant.
- When undefined:
  - Fixed priority, index 0 highest.
  - Pointer logic is absent.

Decomposition:
- Package axi_read_arbiter_pkg:
  - State enum arb_state_t {IDLE, ADDR, DATA}.
  - Constant AXI_BURST_INCR=2'd1.
  - Constant AXI_LEN_W=8.
- Sub-module axi_arb_picker:
  - Combinational.
  - Inputs: req vector and start index.
  - Outputs: one-hot grant and encoded index.
  - Fixed priority is the start=0 case.

Test Plan:
- Single request: req_valid[1]=1, addr=0x0010_0000, len=31, ar_ready=1 on the 2nd ADDR cycle, 32 r beats (last on beat 31).
  - Expect: req_ready[1] pulse once; ar_addr=0x0010_0000, ar_len=31; rsp_valid[1] high exactly 32 cycles, each 1 cycle after its r_valid; rsp_valid[0] never set; len_err=0.
- Simultaneous requests, fixed priority: req 0 (addr 0x1000, len 3) and req 1 (addr 0x2000, len 7) both asserted.
  - Expect: req 0 granted first, req 1 granted in the IDLE cycle after req 0's r_last.
  - Expect: AR order 0x1000 then 0x2000; rsp beats 4 then 8.
- Round robin (macro defined): both requesters assert continuously for 4 bursts.
  - Expect grant order 0,1,0,1. Without the macro: 0,0,0,0.
- Length mismatch: len=7, slave asserts r_last on beat 5.
  - Expect: len_err=1 from the next cycle and held; state returns to IDLE; a subsequent burst completes normally.
- Reset mid-burst: assert reset for 1 cycle after beat 3 of a len=15 burst.
  - Expect next cycle: ar_valid=0, rsp_valid=0, busy=0, len_err=0.
  - Expect: a new request is then granted normally.
- AR backpressure: hold ar_ready=0 for 10 cycles.
  - Expect: ar_valid, addr and len stable all 10 cycles; r_ready=0; r_valid injected during ADDR is ignored (no rsp_valid).

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the AXI read-port arbiter.
package axi_read_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'd1;
  localparam int unsigned AXI_LEN_W      = 8;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_arb_picker.sv
// Combinational rotating-priority picker: searches req_i from start_i upward
// and wraps. A start index of zero gives plain fixed priority.
module axi_arb_picker
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = int'(start_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j[IDX_W-1:0]]) begin
        any_o                   = 1'b1;
        grant_o[j[IDX_W-1:0]]   = 1'b1;
        idx_o                   = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// One-outstanding-burst arbiter sharing an AXI4 read port among NUM_REQ clients.
// Define AXI_READ_ARBITER_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*32-1:0]       req_addr,
  input  logic [NUM_REQ*AXI_LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_last,
  output logic                        busy,
  output logic                        len_err,
  output logic                        axi_ar_valid,
  input  logic                        axi_ar_ready,
  output logic [31:0]                 axi_ar_payload_addr,
  output logic [AXI_LEN_W-1:0]        axi_ar_payload_len,
  output logic [1:0]                  axi_ar_payload_burst,
  input  logic                        axi_r_valid,
  output logic                        axi_r_ready,
  input  logic [DATA_W-1:0]           axi_r_payload_data,
  input  logic                        axi_r_payload_last
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [31:0]          addr_q, addr_d;
  logic [AXI_LEN_W-1:0] len_q, len_d;
  logic [8:0]           beat_cnt_q, beat_cnt_d;
  logic                 len_err_q, len_err_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [IDX_W-1:0]     start_idx;

`ifdef AXI_READ_ARBITER_ROUND_ROBIN_EN
  logic [IDX_W-1:0]     rr_q, rr_d;
  assign start_idx = rr_q;
`else
  assign start_idx = '0;
`endif

  axi_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req_valid),
    .start_i (start_idx),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    len_err_d   = len_err_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    req_ready   = '0;
`ifdef AXI_READ_ARBITER_ROUND_ROBIN_EN
    rr_d        = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          owner_d   = pick_idx;
          addr_d    = req_addr[32*pick_idx +: 32];
          len_d     = req_len[AXI_LEN_W*pick_idx +: AXI_LEN_W];
          state_d   = ADDR;
`ifdef AXI_READ_ARBITER_ROUND_ROBIN_EN
          rr_d      = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
`endif
        end
      end
      ADDR: begin
        if (axi_ar_ready) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (axi_r_valid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = axi_r_payload_data;
          rsp_last_d           = axi_r_payload_last;
          beat_cnt_d           = beat_cnt_q + 9'd1;
          // Short burst flags on r_last; over-long burst flags on the beat past len.
          if (axi_r_payload_last) begin
            state_d = IDLE;
            if (beat_cnt_q != {1'b0, len_q}) len_err_d = 1'b1;
          end else if (beat_cnt_q == {1'b0, len_q}) begin
            len_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      len_err_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
`ifdef AXI_READ_ARBITER_ROUND_ROBIN_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      len_err_q   <= len_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
`ifdef AXI_READ_ARBITER_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign axi_ar_valid         = (state_q == ADDR);
  assign axi_r_ready          = (state_q == DATA);
  assign busy                 = (state_q != IDLE);
  assign axi_ar_payload_addr  = addr_q;
  assign axi_ar_payload_len   = len_q;
  assign axi_ar_payload_burst = AXI_BURST_INCR;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_data             = rsp_data_q;
  assign rsp_last             = rsp_last_q;
  assign len_err              = len_err_q;

endmodule
